// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// rtl/hazard_ctrl_unit_if.sv - pipeline status inputs and stall/flush/forward controls
interface hazard_ctrl_unit_if
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              ihit;
    logic              dhit;
    logic              dmem_req;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_use;
    logic              id_rt_use;
    logic              id_jump;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_wsel;
    logic              ex_wen;
    logic              ex_memread;
    logic              ex_br_taken;
    logic [REG_AW-1:0] mem_wsel;
    logic              mem_wen;
    logic [REG_AW-1:0] wb_wsel;
    logic              wb_wen;
    logic              wb_halt;

    logic              pc_en;
    logic              fetch_en;
    logic              decode_en;
    logic              execute_en;
    logic              memory_en;
    logic              decode_flush;
    logic              execute_flush;
    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;
    logic              halted;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output ihit, dhit, dmem_req, id_rs, id_rt, id_rs_use, id_rt_use, id_jump,
               ex_rs, ex_rt, ex_wsel, ex_wen, ex_memread, ex_br_taken,
               mem_wsel, mem_wen, wb_wsel, wb_wen, wb_halt,
        input  pc_en, fetch_en, decode_en, execute_en, memory_en,
               decode_flush, execute_flush, fwd_a, fwd_b, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, dmem_req, id_rs, id_rt, id_rs_use, id_rt_use, id_jump,
               ex_rs, ex_rt, ex_wsel, ex_wen, ex_memread, ex_br_taken,
               mem_wsel, mem_wen, wb_wsel, wb_wen, wb_halt,
        output pc_en, fetch_en, decode_en, execute_en, memory_en,
               decode_flush, execute_flush, fwd_a, fwd_b, halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// rtl/hazard_ctrl_unit_fwd_sel.sv - forward select for one EX operand; EN=0 pins it to the regfile
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter bit EN     = 1'b1
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] mem_wsel,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] wb_wsel,
    input  logic              wb_wen,
    output fwd_sel_t          sel
);

    // The younger MEM result wins over WB when both target the operand.
    always_comb begin
        sel = FWD_RF;
        if (EN && (src != REG_AW'(REG_ZERO))) begin
            if (mem_wen && (mem_wsel == src)) begin
                sel = FWD_MEM;
            end else if (wb_wen && (wb_wsel == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - stall/flush/forward controller; HAZARD_FORWARD_EN enables EX forwarding
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic               CLK,
    input  logic               RST,
    hazard_ctrl_unit_if.slave  hz
);

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic             halted_q, halted_d;
    logic             redir_pend_q, redir_pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic     pc_en_c, fetch_en_c, decode_en_c, execute_en_c, memory_en_c;
    logic     decode_flush_c, execute_flush_c;
    logic     stall_inc, flush_inc;
    logic     freeze, load_use;
    logic     raw_ex, raw_mem, raw_wb;
    fwd_sel_t fwd_a_c, fwd_b_c;

    function automatic logic raw_hit(input logic [REG_AW-1:0] x, input logic wen,
                                     input logic [REG_AW-1:0] rs, input logic rs_use,
                                     input logic [REG_AW-1:0] rt, input logic rt_use);
        return (x != REG_AW'(REG_ZERO)) && wen &&
               ((rs_use && (rs == x)) || (rt_use && (rt == x)));
    endfunction

    assign raw_ex  = raw_hit(hz.ex_wsel,  hz.ex_wen,  hz.id_rs, hz.id_rs_use, hz.id_rt, hz.id_rt_use);
    assign raw_mem = raw_hit(hz.mem_wsel, hz.mem_wen, hz.id_rs, hz.id_rs_use, hz.id_rt, hz.id_rt_use);
    assign raw_wb  = raw_hit(hz.wb_wsel,  hz.wb_wen,  hz.id_rs, hz.id_rs_use, hz.id_rt, hz.id_rt_use);

    // Without forwarding every in-flight writer blocks ID until it has left WB.
    assign load_use = FWD_EN ? (hz.ex_memread && raw_ex) : (raw_ex || raw_mem || raw_wb);
    assign freeze   = hz.dmem_req && !hz.dhit;

    always_comb begin
        pc_en_c         = 1'b1;
        fetch_en_c      = 1'b1;
        decode_en_c     = 1'b1;
        execute_en_c    = 1'b1;
        memory_en_c     = 1'b1;
        decode_flush_c  = 1'b0;
        execute_flush_c = 1'b0;
        flush_inc       = 1'b0;
        redir_pend_d    = redir_pend_q;
        halted_d        = halted_q;

        if (halted_q || freeze) begin
            pc_en_c      = 1'b0;
            fetch_en_c   = 1'b0;
            decode_en_c  = 1'b0;
            execute_en_c = 1'b0;
            memory_en_c  = 1'b0;
        end else if (hz.ex_br_taken) begin
            decode_flush_c  = 1'b1;
            execute_flush_c = 1'b1;
            flush_inc       = 1'b1;
            fetch_en_c      = hz.ihit;
            // A miss outstanding at redirect returns a wrong-path word later.
            redir_pend_d    = !hz.ihit;
        end else if (load_use) begin
            pc_en_c         = 1'b0;
            fetch_en_c      = 1'b0;
            decode_en_c     = 1'b0;
            execute_flush_c = 1'b1;
        end else if (!hz.ihit) begin
            pc_en_c        = 1'b0;
            fetch_en_c     = 1'b0;
            decode_flush_c = 1'b1;
        end else if (redir_pend_q) begin
            decode_flush_c = 1'b1;
            redir_pend_d   = 1'b0;
        end else if (hz.id_jump) begin
            decode_flush_c = 1'b1;
            flush_inc      = 1'b1;
        end

        if (!halted_q && !freeze && hz.wb_halt) begin
            halted_d = 1'b1;
        end

        stall_inc   = !halted_q && !pc_en_c;
        stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            halted_q     <= 1'b0;
            redir_pend_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            halted_q     <= halted_d;
            redir_pend_q <= redir_pend_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    hazard_fwd_sel #(.REG_AW(REG_AW), .EN(FWD_EN)) u_fwd_a (
        .src      (hz.ex_rs),
        .mem_wsel (hz.mem_wsel),
        .mem_wen  (hz.mem_wen),
        .wb_wsel  (hz.wb_wsel),
        .wb_wen   (hz.wb_wen),
        .sel      (fwd_a_c)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW), .EN(FWD_EN)) u_fwd_b (
        .src      (hz.ex_rt),
        .mem_wsel (hz.mem_wsel),
        .mem_wen  (hz.mem_wen),
        .wb_wsel  (hz.wb_wsel),
        .wb_wen   (hz.wb_wen),
        .sel      (fwd_b_c)
    );

    assign hz.pc_en         = pc_en_c         && !RST;
    assign hz.fetch_en      = fetch_en_c      && !RST;
    assign hz.decode_en     = decode_en_c     && !RST;
    assign hz.execute_en    = execute_en_c    && !RST;
    assign hz.memory_en     = memory_en_c     && !RST;
    assign hz.decode_flush  = decode_flush_c  && !RST;
    assign hz.execute_flush = execute_flush_c && !RST;
    assign hz.fwd_a         = RST ? FWD_RF : fwd_a_c;
    assign hz.fwd_b         = RST ? FWD_RF : fwd_b_c;
    assign hz.halted        = halted_q && !RST;
    assign hz.stall_cnt     = RST ? '0 : stall_cnt_q;
    assign hz.flush_cnt     = RST ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed and random checks of hazard_ctrl_unit against a rule-level model
module tb_hazard_ctrl_unit;
    import hazard_pkg::*;

    localparam int AW = 5;
    localparam int CW = 6;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_FORWARD_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.REG_AW(AW), .CNT_W(CW)) bus ();
    hazard_ctrl_unit #(.REG_AW(AW), .CNT_W(CW)) dut (.CLK(clk), .RST(rst), .hz(bus));

    int errors = 0;
    int checks = 0;

    int m_halted = 0;
    int m_redir  = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.ihit = 1; bus.dhit = 1; bus.dmem_req = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rs_use = 0; bus.id_rt_use = 0; bus.id_jump = 0;
        bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_wsel = 0; bus.ex_wen = 0; bus.ex_memread = 0;
        bus.ex_br_taken = 0; bus.mem_wsel = 0; bus.mem_wen = 0; bus.wb_wsel = 0; bus.wb_wen = 0;
        bus.wb_halt = 0;
    endtask

    function automatic bit reads(input int r);
        return (r != 0) && ((bus.id_rs_use && int'(bus.id_rs) == r) || (bus.id_rt_use && int'(bus.id_rt) == r));
    endfunction

    function automatic bit model_load_use();
        bit ex_hit, mem_hit, wb_hit;
        ex_hit  = bus.ex_wen  && reads(int'(bus.ex_wsel));
        mem_hit = bus.mem_wen && reads(int'(bus.mem_wsel));
        wb_hit  = bus.wb_wen  && reads(int'(bus.wb_wsel));
        if (FE) return bus.ex_memread && ex_hit;
        return ex_hit || mem_hit || wb_hit;
    endfunction

    // {pc, fetch, decode, execute, memory, decode_flush, execute_flush}
    function automatic logic [6:0] model_ctl();
        if (rst) return 7'b0000000;
        if (m_halted != 0) return 7'b0000000;
        if (bus.dmem_req && !bus.dhit) return 7'b0000000;
        if (bus.ex_br_taken) return {1'b1, bus.ihit, 5'b11111};
        if (model_load_use()) return 7'b0001101;
        if (!bus.ihit) return 7'b0011110;
        if (m_redir != 0) return 7'b1111110;
        if (bus.id_jump) return 7'b1111110;
        return 7'b1111100;
    endfunction

    function automatic int model_fwd(input int src);
        if (rst || !FE || src == 0) return 0;
        if (bus.mem_wen && int'(bus.mem_wsel) == src) return 1;
        if (bus.wb_wen && int'(bus.wb_wsel) == src) return 2;
        return 0;
    endfunction

    task automatic compare();
        chk("ctl", int'({bus.pc_en, bus.fetch_en, bus.decode_en, bus.execute_en, bus.memory_en,
                         bus.decode_flush, bus.execute_flush}), int'(model_ctl()));
        chk("fwd_a", int'(bus.fwd_a), model_fwd(int'(bus.ex_rs)));
        chk("fwd_b", int'(bus.fwd_b), model_fwd(int'(bus.ex_rt)));
        chk("halted", int'(bus.halted), rst ? 0 : m_halted);
        chk("stall_cnt", int'(bus.stall_cnt), rst ? 0 : m_stall);
        chk("flush_cnt", int'(bus.flush_cnt), rst ? 0 : m_flush);
    endtask

    // Called right after the edge, while the pre-edge inputs are still applied.
    task automatic update(input logic [6:0] ctl);
        if (rst) begin
            m_halted = 0; m_redir = 0; m_stall = 0; m_flush = 0;
        end else if (m_halted == 0) begin
            if (!ctl[6]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (!(bus.dmem_req && !bus.dhit)) begin
                if (bus.ex_br_taken) begin
                    m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
                    m_redir = bus.ihit ? 0 : 1;
                end else if (!model_load_use() && bus.ihit) begin
                    if (m_redir != 0) m_redir = 0;
                    else if (bus.id_jump) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
                end
                if (bus.wb_halt) m_halted = 1;
            end
        end
    endtask

    task automatic tick();
        logic [6:0] ctl;
        #2;
        compare();
        ctl = model_ctl();
        @(posedge clk);
        update(ctl);
        #1;
    endtask

    initial begin
        rst = 1;
        idle();
        @(posedge clk);
        #1;
        chk("rst_pc_en", int'(bus.pc_en), 0);
        chk("rst_memory_en", int'(bus.memory_en), 0);
        tick();
        tick();
        rst = 0;
        #1;
        chk("idle_pc_en", int'(bus.pc_en), 1);
        chk("idle_stall_cnt", int'(bus.stall_cnt), 0);
        tick();

        // load-use stall
        bus.ex_memread = 1; bus.ex_wen = 1; bus.ex_wsel = 5; bus.id_rs = 5; bus.id_rs_use = 1;
        #1;
        chk("lu_pc_en", int'(bus.pc_en), 0);
        chk("lu_fetch_en", int'(bus.fetch_en), 0);
        chk("lu_decode_en", int'(bus.decode_en), 0);
        chk("lu_execute_flush", int'(bus.execute_flush), 1);
        tick();
        idle();
        #1;
        chk("lu_stall_cnt", int'(bus.stall_cnt), 1);
        tick();

        // forward priority
        bus.ex_rs = 3; bus.mem_wsel = 3; bus.wb_wsel = 3; bus.mem_wen = 1; bus.wb_wen = 1;
        #1;
        chk("fwd_mem_wins", int'(bus.fwd_a), FE ? 1 : 0);
        bus.mem_wen = 0;
        #1;
        chk("fwd_wb", int'(bus.fwd_a), FE ? 2 : 0);
        bus.ex_rs = 0;
        #1;
        chk("fwd_zero_reg", int'(bus.fwd_a), 0);
        tick();
        idle();

        // taken branch during an I-miss, then the wrong-path word returns
        bus.ex_br_taken = 1; bus.ihit = 0;
        #1;
        chk("br_decode_flush", int'(bus.decode_flush), 1);
        chk("br_execute_flush", int'(bus.execute_flush), 1);
        chk("br_pc_en", int'(bus.pc_en), 1);
        chk("br_fetch_en", int'(bus.fetch_en), 0);
        tick();
        bus.ex_br_taken = 0;
        repeat (2) begin
            #1;
            chk("miss_pc_en", int'(bus.pc_en), 0);
            tick();
        end
        bus.ihit = 1;
        #1;
        chk("wrongpath_decode_flush", int'(bus.decode_flush), 1);
        tick();
        #1;
        chk("after_redir_decode_flush", int'(bus.decode_flush), 0);
        chk("br_flush_cnt", int'(bus.flush_cnt), 1);
        tick();

        // D-miss freeze overrides a taken branch
        bus.dmem_req = 1; bus.dhit = 0; bus.ex_br_taken = 1;
        repeat (4) begin
            #1;
            chk("freeze_enables", int'({bus.pc_en, bus.fetch_en, bus.decode_en, bus.execute_en, bus.memory_en}), 0);
            tick();
        end
        idle();
        #1;
        chk("freeze_flush_cnt", int'(bus.flush_cnt), 1);
        chk("freeze_stall_cnt", int'(bus.stall_cnt), 7);
        tick();

        // sticky halt, cleared only by reset
        bus.wb_halt = 1;
        #1;
        chk("halt_not_yet", int'(bus.halted), 0);
        tick();
        bus.wb_halt = 0;
        #1;
        chk("halted_set", int'(bus.halted), 1);
        chk("halted_pc_en", int'(bus.pc_en), 0);
        tick();
        tick();
        chk("halted_stall_frozen", int'(bus.stall_cnt), 7);
        rst = 1;
        #1;
        tick();
        rst = 0;
        #1;
        chk("post_rst_halted", int'(bus.halted), 0);
        chk("post_rst_stall", int'(bus.stall_cnt), 0);
        chk("post_rst_flush", int'(bus.flush_cnt), 0);
        chk("post_rst_pc_en", int'(bus.pc_en), 1);
        tick();

        // WB writer against an ID reader
        bus.wb_wsel = 7; bus.wb_wen = 1; bus.id_rt = 7; bus.id_rt_use = 1; bus.ex_rt = 7;
        #1;
        chk("wb_raw_pc_en", int'(bus.pc_en), FE ? 1 : 0);
        chk("wb_raw_execute_flush", int'(bus.execute_flush), FE ? 0 : 1);
        chk("wb_raw_fwd_b", int'(bus.fwd_b), FE ? 2 : 0);
        tick();
        idle();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(0, 59) == 0);
            bus.ihit        = ($urandom_range(0, 9) < 8);
            bus.dhit        = ($urandom_range(0, 9) < 7);
            bus.dmem_req    = ($urandom_range(0, 9) < 3);
            bus.id_rs       = AW'($urandom_range(0, 3));
            bus.id_rt       = AW'($urandom_range(0, 3));
            bus.id_rs_use   = 1'($urandom_range(0, 1));
            bus.id_rt_use   = 1'($urandom_range(0, 1));
            bus.id_jump     = ($urandom_range(0, 9) == 0);
            bus.ex_rs       = AW'($urandom_range(0, 3));
            bus.ex_rt       = AW'($urandom_range(0, 3));
            bus.ex_wsel     = AW'($urandom_range(0, 3));
            bus.ex_wen      = 1'($urandom_range(0, 1));
            bus.ex_memread  = 1'($urandom_range(0, 1));
            bus.ex_br_taken = ($urandom_range(0, 6) == 0);
            bus.mem_wsel    = AW'($urandom_range(0, 3));
            bus.mem_wen     = 1'($urandom_range(0, 1));
            bus.wb_wsel     = AW'($urandom_range(0, 3));
            bus.wb_wen      = 1'($urandom_range(0, 1));
            bus.wb_halt     = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
